apple2_slot_master: RTL
=======================

// Module: apple2_slot_master
// PURPOSE
//  Apple II bus initiator for bench and bring-up rigs: drives one expansion slot the way the motherboard does.
//  - Generates PHI0/PHI1 from C7M.
//  - Runs one 6502-style bus cycle per machine cycle.
//  - Decodes slot selects (/DEVSEL, /IOSEL, /IOSTRB) from a host transaction.
//  - Returns read data sampled at the end of PHI0.
//  Sits between a host sequencer (req/ack/done) and the slot-card pins.
// PARAMETERS
//  SLOT       3     slot number, 1..7; DEVSEL = $C080+16*SLOT..+$F, IOSEL = $Cn00-$CnFF (n=SLOT)
//  IDLE_ADDR  16'hFFFF  address driven on A in cycles with no transaction (nWE=1, no selects)
// PORTS
//  C7M        in   1   7.16 MHz clock; all logic on posedge
//  nRES       in   1   async active-low reset
//  req        in   1   host request; hold with req_* stable until ack
//  req_addr   in   16  transaction address
//  req_wr     in   1   1=write, 0=read
//  req_wdata  in   8   write data
//  ack        out  1   1-clk pulse: request latched, its bus cycle starts now
//  done       out  1   1-clk pulse: bus cycle finished; rdata valid (reads)
//  rdata      out  8   read data, held until next read's done
//  PHI0       out  1   6502 phase 0
//  PHI1       out  1   ~PHI0
//  A          out  16  address bus
//  nWE        out  1   R/W (0=write)
//  Dout       out  8   data driven to bus
//  DOE        out  1   Dout enable (tristate control at top level)
//  Din        in   8   data bus from card
//  nDEVSEL    out  1   slot device select
//  nIOSEL     out  1   slot I/O ROM select
//  nIOSTRB    out  1   $C800-$CFFF strobe (global, all slots)
// BEHAVIOUR
//  Phase counter P:
//  - Normal cycle: P steps 0..6 then wraps to 0, 7 clocks per machine cycle.
//  - PHI1=1 for P 0..2; PHI0=1 for P 3..6. All outputs registered.
//  Reset (async):
//  - P=0, PHI1=1, PHI0=0, A=IDLE_ADDR, nWE=1, DOE=0, Dout=0.
//  - All selects 1, ack=0, done=0, rdata=0; pending transaction discarded.
//  Launch (at P=6 -> 0 transition):
//  - If req=1: latch req_*, pulse ack with P=0, drive A=req_addr and nWE=~req_wr for the whole cycle.
//  - Otherwise: A=IDLE_ADDR, nWE=1.
//  - A request raised mid-cycle waits for the next launch. Back-to-back requests give one transaction per machine cycle.
//  Selects:
//  - Low for P 3..6 only (PHI0), decoded from the latched address; high at P 0..2.
//  - $CFFF asserts nIOSTRB (no special casing here).
//  - Selects are mutually exclusive by decode; idle cycles assert none.
//  Write data: DOE=1 and Dout=wdata for P 4..6 of write cycles (1 clk after PHI0 rise); DOE=0 otherwise.
//  Read capture: rdata<=Din on the clock ending P=6 (same edge PHI0 falls); done pulses with the next P=0.
//  Done for a write also pulses at that point; rdata is unchanged on writes.
//  ack and done can coincide at the same P=0 (back-to-back traffic).
//  Reset mid-cycle: selects and DOE deassert immediately (async). No done for the aborted transaction.
// CONFIGURATION
//  APPLE2_STRETCH_EN defined:
//  - A 7-bit cycle counter counts machine cycles 0..64.
//  - In cycle 64 P holds at 2 for one extra clock (PHI1 = 4 clks, 8 clks total); then counter wraps to 0.
//  - PHI0 width is always 4 clks. Counter reset value 0.
//  APPLE2_STRETCH_EN not defined: every cycle is 7 clks; counter absent.
// TESTING
//  1 Reset release, req=0 for 10 cycles -> PHI0 period 7 clks (3 low/4 high), A=$FFFF, all selects 1, DOE=0.
//  2 SLOT=3, read $C0B2, Din=$5A -> nDEVSEL low P3..6 only, nWE=1; rdata=$5A, done 1 clk at next P=0.
//  3 Write $C345=$A7 -> nIOSEL low P3..6, nWE=0, DOE=1 P4..6 with Dout=$A7; rdata unchanged.
//  4 Reads $C800 then $CFFF back-to-back -> nIOSTRB low both cycles; ack and done coincide at 2nd P=0.
//  5 nRES low at P=5 of a write -> DOE, selects to 1 async; no done; PHI1=1 and P=0 on release.
//  6 APPLE2_STRETCH_EN: count 130 machine cycles -> exactly 2 cycles of 8 clks, 65 apart, PHI0 always 4 clks.

Source files
------------

// File: rtl/apple2_slot_master_if.sv
// Host handshake and slot-pin bundle for the Apple II slot bus initiator.
// master = the initiator's side; slave = the host/card side.
interface apple2_slot_master_if;
   logic        req;
   logic [15:0] req_addr;
   logic        req_wr;
   logic [7:0]  req_wdata;
   logic        ack;
   logic        done;
   logic [7:0]  rdata;
   logic        PHI0;
   logic        PHI1;
   logic [15:0] A;
   logic        nWE;
   logic [7:0]  Dout;
   logic        DOE;
   logic [7:0]  Din;
   logic        nDEVSEL;
   logic        nIOSEL;
   logic        nIOSTRB;

   modport master (
      input  req, req_addr, req_wr, req_wdata, Din,
      output ack, done, rdata, PHI0, PHI1, A, nWE, Dout, DOE,
             nDEVSEL, nIOSEL, nIOSTRB
   );

   modport slave (
      output req, req_addr, req_wr, req_wdata, Din,
      input  ack, done, rdata, PHI0, PHI1, A, nWE, Dout, DOE,
             nDEVSEL, nIOSEL, nIOSTRB
   );
endinterface

// File: rtl/apple2_slot_master.sv
// Apple II slot bus initiator: PHI0/PHI1 from C7M, one host transaction per machine cycle.
// Optional APPLE2_STRETCH_EN: every 65th machine cycle has PHI1 stretched by one C7M clock.
//
// state | meaning
// PH0   | PHI1 high, new transaction launched (ack/done pulse here)
// PH1   | PHI1 high
// PH2   | PHI1 high; held one extra clock in a stretched cycle
// PH3   | PHI0 high, selects asserted
// PH4   | PHI0 high, write data driven
// PH5   | PHI0 high, write data driven
// PH6   | PHI0 high, read data captured on the exiting edge
module apple2_slot_master #(
   parameter int          SLOT      = 3,
   parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
   input logic                    C7M,
   input logic                    nRES,
   apple2_slot_master_if.master   bus
);

   typedef enum logic [2:0] {PH0, PH1, PH2, PH3, PH4, PH5, PH6} phase_e;

   phase_e      ph, ph_nxt;
   logic        busy, busy_nxt;
   logic        wr_lat, wr_nxt;
   logic [7:0]  wdata_lat, wdata_nxt;
   logic [15:0] a_nxt;
   logic        nwe_nxt, ack_nxt, done_nxt;
   logic [7:0]  rdata_nxt, dout_nxt;
   logic        phi0_nxt, win, doe_nxt;
   logic        ndev_nxt, nio_nxt, nstrb_nxt;
   logic        dev_hit, io_hit, strb_hit;

`ifdef APPLE2_STRETCH_EN
   logic [6:0]  cyc, cyc_nxt;
   logic        held, held_nxt;
`endif

   // A holds the latched address for the whole cycle, so decode straight from it
   assign dev_hit  = (bus.A[15:4] == (12'hC08 + 12'(SLOT)));
   assign io_hit   = (bus.A[15:8] == (8'hC0 + 8'(SLOT)));
   assign strb_hit = (bus.A[15:11] == 5'b11001);

   always_comb begin
      ph_nxt    = ph;
      busy_nxt  = busy;
      wr_nxt    = wr_lat;
      wdata_nxt = wdata_lat;
      a_nxt     = bus.A;
      nwe_nxt   = bus.nWE;
      ack_nxt   = 1'b0;
      done_nxt  = 1'b0;
      rdata_nxt = bus.rdata;
`ifdef APPLE2_STRETCH_EN
      cyc_nxt   = cyc;
      held_nxt  = held;
`endif

      case (ph)
         PH0: ph_nxt = PH1;
         PH1: ph_nxt = PH2;
         PH2: begin
`ifdef APPLE2_STRETCH_EN
            if (cyc == 7'd64 && !held) begin
               ph_nxt   = PH2;
               held_nxt = 1'b1;
            end else begin
               ph_nxt = PH3;
            end
`else
            ph_nxt = PH3;
`endif
         end
         PH3: ph_nxt = PH4;
         PH4: ph_nxt = PH5;
         PH5: ph_nxt = PH6;
         PH6: ph_nxt = PH0;
         default: ph_nxt = PH0;
      endcase

      if (ph == PH6) begin
         done_nxt = busy;
         if (busy && !wr_lat) rdata_nxt = bus.Din;
         busy_nxt = bus.req;
         ack_nxt  = bus.req;
         if (bus.req) begin
            a_nxt     = bus.req_addr;
            nwe_nxt   = ~bus.req_wr;
            wr_nxt    = bus.req_wr;
            wdata_nxt = bus.req_wdata;
         end else begin
            a_nxt     = IDLE_ADDR;
            nwe_nxt   = 1'b1;
            wr_nxt    = 1'b0;
         end
`ifdef APPLE2_STRETCH_EN
         held_nxt = 1'b0;
         cyc_nxt  = (cyc == 7'd64) ? 7'd0 : cyc + 7'd1;
`endif
      end

      phi0_nxt  = (ph_nxt inside {PH3, PH4, PH5, PH6});
      win       = phi0_nxt && busy;
      ndev_nxt  = ~(win && dev_hit);
      nio_nxt   = ~(win && io_hit);
      nstrb_nxt = ~(win && strb_hit);
      doe_nxt   = busy && wr_lat && (ph_nxt inside {PH4, PH5, PH6});
      dout_nxt  = doe_nxt ? wdata_lat : 8'h00;
   end

   always_ff @(posedge C7M or negedge nRES) begin
      if (!nRES) begin
         ph          <= PH0;
         busy        <= 1'b0;
         wr_lat      <= 1'b0;
         wdata_lat   <= 8'h00;
         bus.A       <= IDLE_ADDR;
         bus.nWE     <= 1'b1;
         bus.ack     <= 1'b0;
         bus.done    <= 1'b0;
         bus.rdata   <= 8'h00;
         bus.PHI0    <= 1'b0;
         bus.PHI1    <= 1'b1;
         bus.nDEVSEL <= 1'b1;
         bus.nIOSEL  <= 1'b1;
         bus.nIOSTRB <= 1'b1;
         bus.DOE     <= 1'b0;
         bus.Dout    <= 8'h00;
`ifdef APPLE2_STRETCH_EN
         cyc         <= 7'd0;
         held        <= 1'b0;
`endif
      end else begin
         ph          <= ph_nxt;
         busy        <= busy_nxt;
         wr_lat      <= wr_nxt;
         wdata_lat   <= wdata_nxt;
         bus.A       <= a_nxt;
         bus.nWE     <= nwe_nxt;
         bus.ack     <= ack_nxt;
         bus.done    <= done_nxt;
         bus.rdata   <= rdata_nxt;
         bus.PHI0    <= phi0_nxt;
         bus.PHI1    <= ~phi0_nxt;
         bus.nDEVSEL <= ndev_nxt;
         bus.nIOSEL  <= nio_nxt;
         bus.nIOSTRB <= nstrb_nxt;
         bus.DOE     <= doe_nxt;
         bus.Dout    <= dout_nxt;
`ifdef APPLE2_STRETCH_EN
         cyc         <= cyc_nxt;
         held        <= held_nxt;
`endif
      end
   end

endmodule
